// File: rtl/mips_run_controller.sv
// Run sequencer for the MIPS pipeline core: drives core reset and forwarding enable,
// counts RUN cycles until halt or budget, optionally sweeping forwarding off then on.
module mips_run_controller #(
    parameter int RST_CYCLES = 1,
    parameter int MAX_CYCLES = 49,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode_sweep,
    input  logic                    fwd_sel,
    input  logic                    halt_in,
    output logic                    core_rst,
    output logic                    forwarding_EN,
    output logic                    running,
    output logic                    done,
    output logic                    timeout,
    output logic                    run_idx,
    output logic [CNT_W-1:0]        cycles_fwd_off,
    output logic [CNT_W-1:0]        cycles_fwd_on,
    output logic signed [CNT_W:0]   fwd_gain
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RESET = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    logic [1:0]       state;
    logic [RW-1:0]    rst_cnt;
    logic [CNT_W-1:0] cnt;
    logic             sweep;
    logic             run_end;

    // Halt and budget limit share one exit; the recorded value is cnt either way
    // because the budget exit only fires when cnt already equals MAX_CYCLES.
    assign run_end = (state == RUN) && (halt_in || (cnt == CNT_W'(MAX_CYCLES)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            rst_cnt        <= '0;
            cnt            <= '0;
            sweep          <= 1'b0;
            forwarding_EN  <= 1'b1;
            done           <= 1'b0;
            timeout        <= 1'b0;
            run_idx        <= 1'b0;
            cycles_fwd_off <= '0;
            cycles_fwd_on  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= RESET;
                        rst_cnt        <= '0;
                        cnt            <= '0;
                        sweep          <= mode_sweep;
                        forwarding_EN  <= mode_sweep ? 1'b0 : fwd_sel;
                        done           <= 1'b0;
                        timeout        <= 1'b0;
                        run_idx        <= 1'b0;
                        cycles_fwd_off <= '0;
                        cycles_fwd_on  <= '0;
                    end
                end
                RESET: begin
                    if (rst_cnt == RW'(RST_CYCLES - 1)) begin
                        state <= RUN;
                        cnt   <= CNT_W'(1);
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (run_end) begin
                        if (forwarding_EN) cycles_fwd_on  <= cnt;
                        else               cycles_fwd_off <= cnt;
                        if (!halt_in) timeout <= 1'b1;
                        // First run of a sweep: re-reset the core with forwarding on
                        if (sweep && !run_idx) begin
                            run_idx       <= 1'b1;
                            forwarding_EN <= 1'b1;
                            rst_cnt       <= '0;
                            state         <= RESET;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign core_rst = (state != RUN);
    assign running  = (state == RUN);
    assign fwd_gain = $signed({1'b0, cycles_fwd_off}) - $signed({1'b0, cycles_fwd_on});

endmodule

// File: tb/tb_mips_run_controller.sv
// Randomized bench for mips_run_controller, checked against a per-run model of
// run length, timeout and result routing derived from halt positions.
module tb_mips_run_controller;

    localparam int RST = 2;
    localparam int MAX = 20;
    localparam int W   = 16;

    logic clk, rst, start, mode_sweep, fwd_sel, halt_in;
    logic core_rst, forwarding_EN, running, done, timeout, run_idx;
    logic [W-1:0] cycles_fwd_off, cycles_fwd_on;
    logic signed [W:0] fwd_gain;

    int n_chk, n_fail;

    mips_run_controller #(.RST_CYCLES(RST), .MAX_CYCLES(MAX), .CNT_W(W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_sweep(mode_sweep),
        .fwd_sel(fwd_sel), .halt_in(halt_in), .core_rst(core_rst),
        .forwarding_EN(forwarding_EN), .running(running), .done(done),
        .timeout(timeout), .run_idx(run_idx), .cycles_fwd_off(cycles_fwd_off),
        .cycles_fwd_on(cycles_fwd_on), .fwd_gain(fwd_gain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // A halt at RUN cycle h (1..MAX) ends the run there; anything else runs the full budget.
    function automatic int run_len(input int h);
        return (h >= 1 && h <= MAX) ? h : MAX;
    endfunction

    function automatic bit run_to(input int h);
        return !(h >= 1 && h <= MAX);
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_core_rst"}, 32'(core_rst), 1);
        check({tag, "_fwd"},      32'(forwarding_EN), 1);
        check({tag, "_running"},  32'(running), 0);
        check({tag, "_done"},     32'(done), 0);
        check({tag, "_timeout"},  32'(timeout), 0);
        check({tag, "_run_idx"},  32'(run_idx), 0);
        check({tag, "_off"},      32'(cycles_fwd_off), 0);
        check({tag, "_on"},       32'(cycles_fwd_on), 0);
        check({tag, "_gain"},     32'(fwd_gain), 0);
    endtask

    // Called at a negedge in IDLE/DONE; returns at the negedge after DONE was checked twice.
    task automatic do_seq(input bit sw, input bit fs, input int h0, input int h1, input bit noise);
        int  res [2];
        int  nruns, h, exp_off, exp_on;
        bit  fwd_k, to_acc;
        nruns = sw ? 2 : 1;
        res[0] = run_len(h0);
        res[1] = run_len(h1);
        exp_off = 0; exp_on = 0; to_acc = 0; fwd_k = 0;
        start = 1; mode_sweep = sw; fwd_sel = fs; halt_in = 0;
        @(negedge clk);
        start = 0;
        for (int k = 0; k < nruns; k++) begin
            fwd_k = sw ? (k == 1) : fs;
            h = (k == 0) ? h0 : h1;
            for (int i = 0; i < RST; i++) begin
                check("rst_core_rst", 32'(core_rst), 1);
                check("rst_running",  32'(running), 0);
                check("rst_fwd",      32'(forwarding_EN), 32'(fwd_k));
                check("rst_run_idx",  32'(run_idx), k);
                check("rst_timeout",  32'(timeout), 32'(to_acc));
                halt_in = noise ? 1'($urandom) : 1'b0;
                @(negedge clk);
            end
            for (int c = 1; c <= res[k]; c++) begin
                check("run_core_rst", 32'(core_rst), 0);
                check("run_running",  32'(running), 1);
                check("run_fwd",      32'(forwarding_EN), 32'(fwd_k));
                check("run_run_idx",  32'(run_idx), k);
                check("run_done",     32'(done), 0);
                check("run_timeout",  32'(timeout), 32'(to_acc));
                halt_in = (c == h);
                if (noise) begin
                    start      = ($urandom_range(0, 5) == 0);
                    mode_sweep = 1'($urandom);
                    fwd_sel    = 1'($urandom);
                end
                @(negedge clk);
            end
            to_acc = to_acc | run_to(h);
            if (fwd_k) exp_on = res[k];
            else       exp_off = res[k];
        end
        start = 0; halt_in = 0;
        for (int j = 0; j < 2; j++) begin
            check("done_done",     32'(done), 1);
            check("done_core_rst", 32'(core_rst), 1);
            check("done_running",  32'(running), 0);
            check("done_fwd",      32'(forwarding_EN), 32'(fwd_k));
            check("done_timeout",  32'(timeout), 32'(to_acc));
            check("done_run_idx",  32'(run_idx), 32'(sw));
            check("done_off",      32'(cycles_fwd_off), exp_off);
            check("done_on",       32'(cycles_fwd_on), exp_on);
            check("done_gain",     32'(fwd_gain), exp_off - exp_on);
            halt_in = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
        end
        halt_in = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk = 0; n_fail = 0;
        rst = 1; start = 0; mode_sweep = 0; fwd_sel = 0; halt_in = 0;

        // 1: reset held, then released with no start
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("reset");
        end
        rst = 0;
        repeat (3) begin
            halt_in = 1'($urandom);
            @(negedge clk);
            check_reset_vals("idle");
        end
        halt_in = 0;

        // 2..5: directed runs
        do_seq(1'b0, 1'b1, 7, 0, 1'b0);
        do_seq(1'b1, 1'b0, 12, 8, 1'b0);
        do_seq(1'b0, 1'b0, 0, 0, 1'b0);
        do_seq(1'b1, 1'b1, 5, 5, 1'b0);
        do_seq(1'b0, 1'b1, 20, 0, 1'b0);
        do_seq(1'b1, 1'b0, 0, 3, 1'b0);

        // 6: start ignored in RUN, then async reset between edges
        start = 1; mode_sweep = 1; fwd_sel = 1;
        @(negedge clk);
        start = 0;
        repeat (RST + 3) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        check("abort_running",  32'(running), 1);
        check("abort_core_rst", 32'(core_rst), 0);
        check("abort_fwd",      32'(forwarding_EN), 0);
        #2 rst = 1;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check_reset_vals("post_abort");
        do_seq(1'b1, 1'b0, 9, 14, 1'b0);

        // Randomized sequences with noise on ignored inputs
        for (int r = 0; r < 20; r++) begin
            do_seq(1'($urandom), 1'($urandom), int'($urandom_range(0, MAX + 2)),
                   int'($urandom_range(0, MAX + 2)), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_run_controller.md
Name: mips_run_controller

Overview:
- Synthesizable run sequencer for the MIPS pipeline core. It generalises the fixed bring-up sequence (reset pulse, forwarding enable, fixed cycle budget) into a parametrised controller.
- Features: configurable reset length and cycle budget, single-run or forwarding-off/on sweep mode, halt detection, timeout flag, and per-mode cycle counts.
- Sits beside MIPS_Processor and drives its rst and forwarding_EN inputs.

Parameters:
- RST_CYCLES, 1, cycles core_rst is held high before each run (>=1)
- MAX_CYCLES, 49, RUN-cycle budget per run before timeout (>=1, < 2^CNT_W)
- CNT_W, 16, width of cycle counters and results

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request to begin a sequence
- mode_sweep  in  1  1 = two runs, forwarding off then on; 0 = single run
- fwd_sel  in  1  forwarding setting for a single run
- halt_in  in  1  core reached its end-of-program condition
- core_rst  out  1  reset to the processor core
- forwarding_EN  out  1  forwarding enable to the processor core
- running  out  1  high in RUN state
- done  out  1  sequence complete; held until next accepted start
- timeout  out  1  sticky: some run hit MAX_CYCLES without a halt
- run_idx  out  1  0 = first run, 1 = second run of a sweep
- cycles_fwd_off  out  CNT_W  RUN cycles of the forwarding-off run
- cycles_fwd_on  out  CNT_W  RUN cycles of the forwarding-on run
- fwd_gain  out  CNT_W+1  signed, cycles_fwd_off - cycles_fwd_on; valid when done and sweep

Behaviour:
- Reset (asynchronous) values:
  - state IDLE, core_rst=1, forwarding_EN=1, running=0, done=0, timeout=0, run_idx=0.
  - All counts and fwd_gain=0.
- States: IDLE, RESET, RUN, DONE.
- IDLE/DONE:
  - core_rst=1.
  - start=1 at an edge latches mode_sweep and fwd_sel; clears done, timeout, counts and run_idx; enters RESET.
  - forwarding_EN is set to 0 if sweep, otherwise to fwd_sel. It is stable for the whole run.
- RESET:
  - core_rst=1 for exactly RST_CYCLES cycles, then RUN.
  - core_rst falls on the edge entering RUN.
- RUN:
  - core_rst=0, running=1.
  - The cycle counter is 1 in the first RUN cycle and increments each cycle.
  - halt_in=1 sampled at an edge records the current count, with the halt cycle included, and ends the run.
  - If the count equals MAX_CYCLES with halt_in=0, the run records MAX_CYCLES, sets timeout, and ends.
  - halt_in and the budget limit in the same cycle: halt wins, timeout is not set.
- Run end:
  - The result goes to cycles_fwd_on if forwarding_EN=1, otherwise to cycles_fwd_off.
  - If sweep and run_idx=0: run_idx becomes 1, forwarding_EN becomes 1, and the controller re-enters RESET. The core is re-reset for RST_CYCLES cycles.
  - Otherwise the controller enters DONE. done=1 from the edge after the ending cycle. core_rst returns to 1.
- fwd_gain is computed combinationally from the two registered counts, sign-extended.
- Ignored inputs:
  - start is ignored in RESET and RUN.
  - halt_in is ignored outside RUN.
  - mode_sweep and fwd_sel are used only at the start edge.
- timeout is sticky across both runs of a sweep and is cleared only by an accepted start or rst.
- rst asserted mid-sequence returns all outputs to their reset values immediately, without waiting for a clock edge.

Test Plan (RST_CYCLES=2, MAX_CYCLES=20, CNT_W=16):
1. rst=1 for 3 cycles, then release with no start -> core_rst=1, forwarding_EN=1, done=0, timeout=0, counts=0 throughout.
2. Single run, fwd_sel=1, halt_in pulsed in the 7th RUN cycle -> core_rst high 2 cycles after start, then low 7 cycles; cycles_fwd_on=7, cycles_fwd_off=0, done=1 the next cycle, timeout=0.
3. Sweep, halt in the 12th RUN cycle of run 0 and the 8th of run 1 -> forwarding_EN=0 then 1; core_rst re-asserted 2 cycles between runs; cycles_fwd_off=12, cycles_fwd_on=8, fwd_gain=+4, run_idx=1, done=1.
4. Single run, fwd_sel=0, halt_in never asserted -> cycles_fwd_off=20, timeout=1, done=1. Then sweep with halt_in in the 5th cycle of both runs -> timeout cleared at start, counts 5/5, fwd_gain=0.
5. halt_in first asserted in the 20th RUN cycle -> count=20, timeout=0. Sweep with run 0 timing out and run 1 halting at 3 -> timeout=1 (sticky), fwd_gain=+17.
6. start pulsed during RUN, then rst asserted mid-RUN between clock edges -> start has no effect; outputs take reset values before the next edge; a later start runs normally.
